// File: rtl/bypass_wb_arbiter.sv
// Write-back arbiter for the bypass buffer. Each execution lane owns a small
// in-order queue. A round-robin grant picks one non-empty lane per cycle and
// moves its head entry into a registered write-back port. Issue is blocked
// while the buffer is full or the pipeline stalls, and full queues push back
// on their lanes through O_Ack and O_Stall_Req.
module bypass_wb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 2,
  parameter int WIDTH_IDX  = 8,
  parameter int WIDTH_DATA = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            I_Req,
  input  logic [NUM_REQ*WIDTH_IDX-1:0]  I_Idx,
  input  logic [NUM_REQ*WIDTH_DATA-1:0] I_Data,
  output logic [NUM_REQ-1:0]            O_Ack,
  input  logic                          I_Full,
  input  logic                          I_Stall,
  output logic                          O_WB_Valid,
  output logic [WIDTH_IDX-1:0]          O_WB_Index,
  output logic [WIDTH_DATA-1:0]         O_WB_Data,
  output logic                          O_Stall_Req,
  output logic                          O_Busy
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANE_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_REQ - 1);

  // Queue storage and bookkeeping, one slot set per lane.
  logic [WIDTH_IDX-1:0]  memIdx_q  [NUM_REQ][DEPTH];
  logic [WIDTH_DATA-1:0] memData_q [NUM_REQ][DEPTH];
  logic [PTR_W-1:0]      head_q    [NUM_REQ];
  logic [PTR_W-1:0]      head_d    [NUM_REQ];
  logic [PTR_W-1:0]      tail_q    [NUM_REQ];
  logic [PTR_W-1:0]      tail_d    [NUM_REQ];
  logic [CNT_W-1:0]      count_q   [NUM_REQ];
  logic [CNT_W-1:0]      count_d   [NUM_REQ];

  // Round-robin pointer: lane at which the next grant search starts.
  logic [LANE_W-1:0]     rrPtr_q;
  logic [LANE_W-1:0]     rrPtr_d;

  // Registered write-back port.
  logic                  wbValid_q;
  logic                  wbValid_d;
  logic [WIDTH_IDX-1:0]  wbIndex_q;
  logic [WIDTH_IDX-1:0]  wbIndex_d;
  logic [WIDTH_DATA-1:0] wbData_q;
  logic [WIDTH_DATA-1:0] wbData_d;

  logic [NUM_REQ-1:0]    notEmpty;
  logic [NUM_REQ-1:0]    laneFull;
  logic [NUM_REQ-1:0]    push;
  logic [NUM_REQ-1:0]    pop;
  logic [WIDTH_IDX-1:0]  headIdx   [NUM_REQ];
  logic [WIDTH_DATA-1:0] headData  [NUM_REQ];
  logic [WIDTH_IDX-1:0]  laneIdx   [NUM_REQ];
  logic [WIDTH_DATA-1:0] laneData  [NUM_REQ];
  logic                  issueEn;
  logic                  grantValid;
  logic [LANE_W-1:0]     grantLane;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Per-lane status, ready, and head-entry views; O_Ack looks only at the
  // registered count so a same-cycle pop never opens the lane early.
  for (genvar g = 0; g < NUM_REQ; g++) begin : gLane
    assign laneIdx[g]  = I_Idx[g*WIDTH_IDX +: WIDTH_IDX];
    assign laneData[g] = I_Data[g*WIDTH_DATA +: WIDTH_DATA];
    assign notEmpty[g] = (count_q[g] != '0);
    assign laneFull[g] = (count_q[g] == CNT_FULL);
    assign O_Ack[g]    = (count_q[g] < CNT_FULL);
    assign push[g]     = I_Req[g] & O_Ack[g];
    assign pop[g]      = grantValid && (grantLane == LANE_W'(g));
    assign headIdx[g]  = memIdx_q[g][head_q[g]];
    assign headData[g] = memData_q[g][head_q[g]];
  end

  assign issueEn     = ~I_Full & ~I_Stall;
  assign O_Stall_Req = |laneFull;
  assign O_Busy      = (|notEmpty) | wbValid_q;
  assign O_WB_Valid  = wbValid_q;
  assign O_WB_Index  = wbIndex_q;
  assign O_WB_Data   = wbData_q;

  // Round-robin search from rrPtr_q upward, wrapping, for the first non-empty lane.
  always_comb begin
    int lane;
    grantValid = 1'b0;
    grantLane  = '0;
    lane       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      lane = (int'(rrPtr_q) + k) % NUM_REQ;
      if (issueEn && !grantValid && notEmpty[lane]) begin
        grantValid = 1'b1;
        grantLane  = LANE_W'(lane);
      end
    end
  end

  // Next-state for queue pointers and counts; push and pop together leave the count unchanged.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      head_d[i]  = head_q[i];
      tail_d[i]  = tail_q[i];
      count_d[i] = count_q[i];
      if (push[i]) begin
        tail_d[i] = nextPtr(tail_q[i]);
      end
      if (pop[i]) begin
        head_d[i] = nextPtr(head_q[i]);
      end
      if (push[i] && !pop[i]) begin
        count_d[i] = count_q[i] + CNT_W'(1);
      end else if (pop[i] && !push[i]) begin
        count_d[i] = count_q[i] - CNT_W'(1);
      end
    end
  end

  // Next-state for the write-back register and round-robin pointer; index and data hold when idle.
  always_comb begin
    wbValid_d = 1'b0;
    wbIndex_d = wbIndex_q;
    wbData_d  = wbData_q;
    rrPtr_d   = rrPtr_q;
    if (grantValid) begin
      wbValid_d = 1'b1;
      wbIndex_d = headIdx[grantLane];
      wbData_d  = headData[grantLane];
      rrPtr_d   = (grantLane == LANE_LAST) ? '0 : grantLane + 1'b1;
    end
  end

  // Queue storage is written at the tail on each transfer; contents need no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        memIdx_q[i][tail_q[i]]  <= laneIdx[i];
        memData_q[i][tail_q[i]] <= laneData[i];
      end
    end
  end

  // Queue bookkeeping; reset empties every lane, discarding queued entries.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  // Write-back port and round-robin pointer, cleared immediately on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wbValid_q <= 1'b0;
      wbIndex_q <= '0;
      wbData_q  <= '0;
      rrPtr_q   <= '0;
    end else begin
      wbValid_q <= wbValid_d;
      wbIndex_q <= wbIndex_d;
      wbData_q  <= wbData_d;
      rrPtr_q   <= rrPtr_d;
    end
  end

endmodule
